// File: rtl/jt51_csr_pkg.sv
// Purpose: shared field layout and write-group codes for the per-channel CSR ring.
// Latency: none (types, constants and one combinational helper only).
// Backpressure: n/a.
package jt51_csr_pkg;

    localparam int RL_W  = 2;
    localparam int FB_W  = 3;
    localparam int CON_W = 3;
    localparam int KC_W  = 7;
    localparam int KF_W  = 6;
    localparam int AMS_W = 2;
    localparam int PMS_W = 3;

    // Packed channel record; the member order fixes the bit positions:
    // rl[25:24] fb[23:21] con[20:18] kc[17:11] kf[10:5] ams[4:3] pms[2:0]
    localparam int PACKED_W = RL_W + FB_W + CON_W + KC_W + KF_W + AMS_W + PMS_W;

    typedef struct packed {
        logic [RL_W-1:0]  rl;
        logic [FB_W-1:0]  fb;
        logic [CON_W-1:0] con;
        logic [KC_W-1:0]  kc;
        logic [KF_W-1:0]  kf;
        logic [AMS_W-1:0] ams;
        logic [PMS_W-1:0] pms;
    } ch_fields_t;

    // Register group selected by a write
    typedef enum logic [1:0] {
        GRP_RL_FB_CON = 2'd0,
        GRP_KC        = 2'd1,
        GRP_KF        = 2'd2,
        GRP_PMS_AMS   = 2'd3
    } grp_e;

    // Overlay one register write onto a channel record; fields outside the
    // selected group pass through untouched.
    function automatic ch_fields_t apply_write(input ch_fields_t cur,
                                               input grp_e       grp,
                                               input logic [7:0] din);
        ch_fields_t f;
        f = cur;
        case (grp)
            GRP_RL_FB_CON: begin
                f.rl  = din[7:6];
                f.fb  = din[5:3];
                f.con = din[2:0];
            end
            GRP_KC:      f.kc = din[6:0];
            GRP_KF:      f.kf = din[7:2];
            GRP_PMS_AMS: begin
                f.pms = din[6:4];
                f.ams = din[1:0];
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/jt51_sh.sv
// Purpose: W-bit wide, STAGES-deep resettable shift register; drop is the oldest stage.
// Latency: STAGES clock-enabled ticks from din to drop.
// Backpressure: none; holds all stages while cen is low.
// Ports: rst (async, active high), clk, cen (shift enable), din (head input), drop (tail output).
module jt51_sh #(
    parameter int W      = 26,
    parameter int STAGES = 8
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] drop
);

    logic [STAGES-1:0][W-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (cen) begin
            stage_q <= {stage_q[STAGES-2:0], din};
        end
    end

    assign drop = stage_q[STAGES-1];

endmodule

// File: rtl/jt51_csr_ch_ring.sv
// Purpose: time-multiplexed per-channel register ring with a one-entry write buffer.
// Latency: a write merges within CHANNELS cen ticks and shows CHANNELS cen ticks after the merge.
// Backpressure: busy high while a write is pending; writes during busy or to a bad channel pulse wr_lost.
// Ports: rst/clk/cen control; din, wr, wr_grp, wr_ch write side; busy, wr_lost status;
//        slot plus rl/fb/con/kc/kf/ams/pms give the fields of the channel currently presented.
module jt51_csr_ch_ring
    import jt51_csr_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int CHW      = $clog2(CHANNELS)
) (
    input  logic           rst,
    input  logic           clk,
    input  logic           cen,
    input  logic [7:0]     din,
    input  logic           wr,
    input  logic [1:0]     wr_grp,
    input  logic [CHW-1:0] wr_ch,
    output logic           busy,
    output logic           wr_lost,
    output logic [CHW-1:0] slot,
    output logic [1:0]     rl,
    output logic [2:0]     fb,
    output logic [2:0]     con,
    output logic [6:0]     kc,
    output logic [5:0]     kf,
    output logic [1:0]     ams,
    output logic [2:0]     pms
);

    localparam logic [CHW-1:0] LAST_SLOT = CHW'(CHANNELS - 1);
    localparam logic [CHW:0]   CH_LIM    = (CHW + 1)'(CHANNELS);

    logic [CHW-1:0] slot_q,     slot_d;
    logic           busy_q,     busy_d;
    logic           wr_lost_q,  wr_lost_d;
    logic [7:0]     pend_din_q, pend_din_d;
    grp_e           pend_grp_q, pend_grp_d;
    logic [CHW-1:0] pend_ch_q,  pend_ch_d;

    ch_fields_t tail;
    ch_fields_t ring_in;
    logic [PACKED_W-1:0] tail_bits;

    logic ch_ok;
    logic accept;
    logic merge;

    // The tail of the ring always holds channel slot_q; whatever is fed back
    // at the head returns to the tail after exactly CHANNELS shifts.
    jt51_sh #(
        .W      (PACKED_W),
        .STAGES (CHANNELS)
    ) u_ring (
        .rst  (rst),
        .clk  (clk),
        .cen  (cen),
        .din  (ring_in),
        .drop (tail_bits)
    );

    assign tail = ch_fields_t'(tail_bits);

    always_comb begin
        slot_d     = slot_q;
        busy_d     = busy_q;
        pend_din_d = pend_din_q;
        pend_grp_d = pend_grp_q;
        pend_ch_d  = pend_ch_q;
        ring_in    = tail;

        ch_ok  = ({1'b0, wr_ch} < CH_LIM);
        accept = wr && !busy_q && ch_ok;
        // Merge uses only the registered buffer, so a write accepted this
        // clk can at earliest merge on the following one.
        merge  = cen && busy_q && (slot_q == pend_ch_q);

        // Anything not accepted is reported, including writes arriving on
        // the very clk that drains the buffer.
        wr_lost_d = wr && !accept;

        if (merge) begin
            ring_in = apply_write(tail, pend_grp_q, pend_din_q);
            busy_d  = 1'b0;
        end

        if (accept) begin
            pend_din_d = din;
            pend_grp_d = grp_e'(wr_grp);
            pend_ch_d  = wr_ch;
            busy_d     = 1'b1;
        end

        if (cen) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            busy_q     <= 1'b0;
            wr_lost_q  <= 1'b0;
            pend_din_q <= '0;
            pend_grp_q <= GRP_RL_FB_CON;
            pend_ch_q  <= '0;
        end else begin
            slot_q     <= slot_d;
            busy_q     <= busy_d;
            wr_lost_q  <= wr_lost_d;
            pend_din_q <= pend_din_d;
            pend_grp_q <= pend_grp_d;
            pend_ch_q  <= pend_ch_d;
        end
    end

    assign busy    = busy_q;
    assign wr_lost = wr_lost_q;
    assign slot    = slot_q;
    assign rl      = tail.rl;
    assign fb      = tail.fb;
    assign con     = tail.con;
    assign kc      = tail.kc;
    assign kf      = tail.kf;
    assign ams     = tail.ams;
    assign pms     = tail.pms;

endmodule

// File: doc/jt51_csr_ch_ring.md
JT51_CSR_CH_RING -- requirements
Module: jt51_csr_ch_ring

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, legal range 2..32; number of channel slots in the ring.
REQ-002 SHALL derive localparam CHW = clog2(CHANNELS); channel index width.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port cen  input  1  clock enable; ring advances only when high.
REQ-006 SHALL have port din  input  8  write data.
REQ-007 SHALL have port wr  input  1  write request strobe, sampled every clk regardless of cen.
REQ-008 SHALL have port wr_grp  input  2  field group: 0 RL/FB/CON, 1 KC, 2 KF, 3 PMS/AMS.
REQ-009 SHALL have port wr_ch  input  CHW  target channel.
REQ-010 SHALL have port busy  output  1  pending write not yet applied.
REQ-011 SHALL have port wr_lost  output  1  one-clk pulse; write rejected.
REQ-012 SHALL have port slot  output  CHW  channel whose fields are presented this cycle.
REQ-013 SHALL have ports rl 2, fb 3, con 3, kc 7, kf 6, ams 2, pms 3, all outputs; fields of channel slot.

Function
REQ-014 Storage SHALL be a 26-bit x CHANNELS circular shift register, packed {rl,fb,con,kc,kf,ams,pms}, shifting once per cen.
REQ-015 slot SHALL increment on each cen, wrapping CHANNELS-1 -> 0; field outputs SHALL always belong to channel slot.
REQ-016 Field extraction SHALL be: grp0 rl=din[7:6], fb=din[5:3], con=din[2:0]; grp1 kc=din[6:0]; grp2 kf=din[7:2]; grp3 pms=din[6:4], ams=din[1:0]; unselected fields recirculate unchanged.
REQ-017 wr with busy low SHALL latch {din,wr_grp,wr_ch} into a one-entry pending buffer and set busy on the next clk.
REQ-018 wr with busy high SHALL be ignored and SHALL pulse wr_lost high for exactly the following clk; pending buffer unchanged.
REQ-019 Pending write SHALL be merged into the ring input on the first cen with slot == pending channel, starting from the clk after acceptance.
REQ-020 busy SHALL fall on the clk edge that performs the merge; a wr in that same cycle is still rejected (REQ-018).
REQ-021 Merged value SHALL appear on outputs at the next occurrence of slot == channel, i.e. CHANNELS cen ticks after merge.
REQ-022 wr_ch >= CHANNELS SHALL be rejected as REQ-018 (wr_lost pulse), busy unaffected.
REQ-023 With cen held low, ring, slot and pending buffer SHALL hold; acceptance and rejection still operate per clk.
REQ-024 Worst-case busy time SHALL be CHANNELS cen ticks.

Reset
REQ-025 rst SHALL asynchronously clear all ring storage, pending buffer, slot, busy and wr_lost to 0; all field outputs read 0.
REQ-026 A pending write in flight at reset SHALL be discarded.
REQ-027 First cen after rst release SHALL advance slot 0 -> 1.

Structure
REQ-028 Field widths, bit positions, group codes and packed width 26 SHALL live in shared package jt51_csr_pkg.
REQ-029 Ring storage SHALL instantiate sub-module jt51_sh (width 26, stages CHANNELS, flop-based, resettable).
REQ-030 Slot counter, pending buffer and merge mux SHALL be in jt51_csr_ch_ring itself.

Verification
REQ-031 After reset, cen every clk -> all field outputs 0 for 2*CHANNELS cycles, slot cycles 0..7 then wraps.
REQ-032 CHANNELS=8, wr grp0 din=0xDB ch=3 -> busy high until merge at slot 3; at next slot 3 rl=3, fb=3, con=3; other channels 0.
REQ-033 Write grp1 kc=0x4A then grp2 din=0xFC to ch 5 -> slot 5 shows kc=0x4A, kf=0x3F; rl/fb/con unchanged.
REQ-034 Second wr while busy -> wr_lost one-clk pulse, original write applied, second never appears.
REQ-035 CHANNELS=5, wr_ch=6 -> wr_lost pulse, busy stays 0; slot wraps 4 -> 0.
REQ-036 Assert rst while busy -> busy 0, target channel still 0 after a full ring turn.
